mismatch_scoreboard: RTL and testbench
======================================

MISMATCH_SCOREBOARD -- requirements
Module: mismatch_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of compared output bits.
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter, timestamp and report word.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that begins a test run.
REQ-006 SHALL have port sample_valid, input, 1: ref_vec and dut_vec are a sample this cycle.
REQ-007 SHALL have port ref_vec, input, WIDTH: reference model outputs.
REQ-008 SHALL have port dut_vec, input, WIDTH: DUT outputs.
REQ-009 SHALL have port finish, input, 1: single-cycle end-of-test pulse.
REQ-010 SHALL have port rpt_valid, output, 1: rpt_data holds a valid report word.
REQ-011 SHALL have port rpt_ready, input, 1: sink accepts the word when rpt_valid is also high.
REQ-012 SHALL have port rpt_data, output, CNT_W: report word.
REQ-013 SHALL have port rpt_last, output, 1: marks the final report word.
REQ-014 SHALL have port busy, output, 1: high in RUN and REPORT.
REQ-015 SHALL have port pass, output, 1: high in DONE when the total error count is 0.

Function
REQ-016 SHALL implement states IDLE, RUN, REPORT and DONE; all outputs are registered.
REQ-017 In IDLE or DONE, start SHALL clear all counters and enter RUN on the next cycle; start in RUN or REPORT is ignored.
REQ-018 In RUN, a timestamp counter SHALL be 0 in the first RUN cycle and increment by 1 every cycle.
REQ-019 In RUN, each sample_valid SHALL increment clocks; if ref_vec != dut_vec, it SHALL also increment errors.
REQ-020 For each bit i with ref_vec[i] != dut_vec[i] on a valid sample, errors_i SHALL increment; if errors_i was 0, errortime_i SHALL capture the current timestamp.
REQ-021 All counters and the timestamp SHALL saturate at all-ones and never wrap.
REQ-022 sample_valid outside RUN SHALL be ignored; finish outside RUN SHALL be ignored.
REQ-023 finish in RUN SHALL enter REPORT next cycle; a sample valid in the same cycle as finish SHALL be counted.
REQ-024 REPORT SHALL emit 2+2*WIDTH words in this order: clocks, errors, then errors_0, errortime_0, ... errors_(WIDTH-1), errortime_(WIDTH-1).
REQ-025 rpt_valid SHALL be high throughout REPORT.
REQ-026 rpt_data and rpt_last SHALL stay stable while rpt_valid=1 and rpt_ready=0.
REQ-027 The report SHALL advance by one word per accepted cycle with no bubbles.
REQ-028 After the word with rpt_last is accepted, the block SHALL enter DONE and deassert rpt_valid next cycle.
REQ-029 errortime_i SHALL report 0 when errors_i is 0.
REQ-030 Counter values SHALL be held unchanged through REPORT and DONE until the next start.

Reset
REQ-031 reset SHALL force state IDLE and set all counters, timestamp and word index to 0, and rpt_valid, rpt_last, busy and pass to 0 on the next edge.
REQ-032 reset SHALL take priority over start, finish and any handshake, including mid-RUN and mid-REPORT (report aborted, rpt_valid low next cycle).

Structure
REQ-033 Package sb_pkg SHALL hold the state enum and a function returning NUM_WORDS = 2+2*WIDTH and its index width.
REQ-034 SHALL instantiate sub-module sat_counter (CNT_W, clear/inc, saturating) for every counter and the timestamp.

Verification
REQ-035 Reset, start, 8 matching samples, finish, rpt_ready=1 -> words 8,0,0,0,0,0,0,0,0,0 with rpt_last on word 10; pass=1.
REQ-036 start; mismatches on bit 2 at timestamps 3 and 5, otherwise matching, 6 samples total -> clocks=6, errors=2, errors_2=2, errortime_2=3; pass=0.
REQ-037 Report with rpt_ready toggled 1,0,0,1,... -> each word held while not ready; no word lost or duplicated; 10 words total.
REQ-038 sample_valid together with finish -> sample counted; sample_valid in IDLE/DONE and start during RUN -> no effect.
REQ-039 reset asserted during REPORT word 4 -> rpt_valid=0 and state IDLE next cycle; new start -> counters 0.
REQ-040 CNT_W=4, 20 mismatching samples -> clocks=15 and errors=15 (saturated).

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and sizing helpers for the mismatch scoreboard.
//   state_t      : scoreboard control states
//   num_words()  : number of report words for a given compare width
//   idx_width()  : bits needed to index those report words
package sb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // clocks, errors, then one (errors_i, errortime_i) pair per compared bit
    function automatic int unsigned num_words(input int unsigned width);
        return 2 + 2 * width;
    endfunction

    function automatic int unsigned idx_width(input int unsigned width);
        return $clog2(2 + 2 * width);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   i_clear : zero the count (takes priority over i_inc)
//   i_inc   : add one unless already all-ones
//   o_q     : registered count
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + CNT_W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mismatch_scoreboard.sv
// Compares reference and DUT output vectors during a test run, counts
// samples and mismatches (total and per bit, with first-error timestamp),
// then streams the counters out over a valid/ready report port.
//   clk, reset          : clock, synchronous active-high reset
//   start, finish       : begin run / end run (single-cycle pulses)
//   sample_valid        : ref_vec / dut_vec carry a sample this cycle
//   rpt_valid/ready     : report handshake; rpt_data word, rpt_last final word
//   busy                : high in RUN and REPORT
//   pass                : high in DONE when no mismatches were seen
module mismatch_scoreboard
    import sb_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] ref_vec,
    input  logic [WIDTH-1:0] dut_vec,
    input  logic             finish,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_data,
    output logic             rpt_last,
    output logic             busy,
    output logic             pass
);

    localparam int unsigned NUM_WORDS = num_words(WIDTH);
    localparam int unsigned IDX_W     = idx_width(WIDTH);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_rpt_valid, w_valid_nxt;
    logic               r_rpt_last, w_last_nxt;
    logic [CNT_W-1:0]   r_rpt_data, w_data_nxt;
    logic               r_busy, r_pass;

    logic               w_run, w_clear, w_sample;
    logic [WIDTH-1:0]   w_bit_err;
    logic [CNT_W-1:0]   w_ts, w_clocks, w_errors, w_clocks_pend;
    logic [CNT_W-1:0]   w_errs_q  [WIDTH];
    logic [CNT_W-1:0]   r_errtime [WIDTH];
    logic [CNT_W-1:0]   w_words   [NUM_WORDS];

    assign w_run     = (r_state == ST_RUN);
    assign w_clear   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sample  = w_run && sample_valid;
    assign w_bit_err = w_sample ? (ref_vec ^ dut_vec) : '0;

    sat_counter #(.CNT_W(CNT_W)) u_ts (
        .i_clk(clk), .i_reset(reset), .i_clear(w_clear), .i_inc(w_run), .o_q(w_ts)
    );

    sat_counter #(.CNT_W(CNT_W)) u_clocks (
        .i_clk(clk), .i_reset(reset), .i_clear(w_clear), .i_inc(w_sample), .o_q(w_clocks)
    );

    sat_counter #(.CNT_W(CNT_W)) u_errors (
        .i_clk(clk), .i_reset(reset), .i_clear(w_clear), .i_inc(|w_bit_err), .o_q(w_errors)
    );

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        sat_counter #(.CNT_W(CNT_W)) u_errs (
            .i_clk(clk), .i_reset(reset), .i_clear(w_clear), .i_inc(w_bit_err[gi]),
            .o_q(w_errs_q[gi])
        );
    end

    // First-error timestamp per bit; stays 0 until that bit first mismatches
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (reset || w_clear) begin
                r_errtime[i] <= '0;
            end else if (w_bit_err[i] && (w_errs_q[i] == '0)) begin
                r_errtime[i] <= w_ts;
            end
        end
    end

    // Word 0 is loaded on the finish edge, so it must include a sample
    // arriving in that same cycle; later words read settled counters.
    assign w_clocks_pend = (w_sample && (w_clocks != '1)) ? w_clocks + CNT_W'(1) : w_clocks;

    always_comb begin
        w_words[0] = w_clocks;
        w_words[1] = w_errors;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_words[2 + 2 * i] = w_errs_q[i];
            w_words[3 + 2 * i] = r_errtime[i];
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_rpt_valid <= 1'b0;
            r_rpt_last  <= 1'b0;
            r_rpt_data  <= '0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_rpt_valid <= w_valid_nxt;
            r_rpt_last  <= w_last_nxt;
            r_rpt_data  <= w_data_nxt;
            r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_REPORT);
            r_pass      <= (w_state_nxt == ST_DONE) && (w_errors == '0);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_data_nxt  = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    w_state_nxt = ST_REPORT;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_clocks_pend;
                end
            end
            ST_REPORT: begin
                w_valid_nxt = 1'b1;
                w_last_nxt  = r_rpt_last;
                w_data_nxt  = r_rpt_data;
                if (rpt_ready) begin
                    if (r_rpt_last) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_data_nxt  = '0;
                    end else begin
                        w_idx_nxt  = r_idx + IDX_W'(1);
                        w_last_nxt = (r_idx == IDX_W'(NUM_WORDS - 2));
                        w_data_nxt = w_words[w_idx_nxt];
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign rpt_valid = r_rpt_valid;
    assign rpt_last  = r_rpt_last;
    assign rpt_data  = r_rpt_data;
    assign busy      = r_busy;
    assign pass      = r_pass;

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// Directed bench for mismatch_scoreboard: default instance (WIDTH=4, CNT_W=32)
// plus a CNT_W=4 instance sharing the same stimulus for saturation.
module tb_mismatch_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [3:0]  ref_vec = '0;
    logic [3:0]  dut_vec = '0;
    logic        finish = 1'b0;
    logic        rpt_ready = 1'b0;

    logic        rpt_valid, rpt_last, busy, pass;
    logic [31:0] rpt_data;
    logic        rpt_valid4, rpt_last4, busy4, pass4;
    logic [3:0]  rpt_data4;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] got_data  [16];
    logic [31:0] got_data4 [16];
    logic        got_last  [16];
    int          got_n;
    int unsigned exp_w     [10];

    always #5 clk = ~clk;

    mismatch_scoreboard dut (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .ref_vec(ref_vec), .dut_vec(dut_vec), .finish(finish),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_data(rpt_data),
        .rpt_last(rpt_last), .busy(busy), .pass(pass)
    );

    mismatch_scoreboard #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .ref_vec(ref_vec), .dut_vec(dut_vec), .finish(finish),
        .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready), .rpt_data(rpt_data4),
        .rpt_last(rpt_last4), .busy(busy4), .pass(pass4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic [3:0] r, input logic [3:0] d);
        sample_valid = 1'b1;
        ref_vec      = r;
        dut_vec      = d;
        tick();
        sample_valid = 1'b0;
        ref_vec      = '0;
        dut_vec      = '0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    // Drain the report; mode 0: always ready, mode 1: ready pattern 1,0,0,...
    task automatic collect(input int mode);
        bit          done;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        got_n      = 0;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            rpt_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            chk("rpt_valid_in_report", 32'(rpt_valid), 32'd1);
            if (!rpt_valid) break;
            if (prev_stall) begin
                chk("hold_data", rpt_data, prev_data);
                chk("hold_last", 32'(rpt_last), 32'(prev_last));
            end
            if (rpt_ready) begin
                if (got_n < 16) begin
                    got_data[got_n]  = rpt_data;
                    got_data4[got_n] = 32'(rpt_data4);
                    got_last[got_n]  = rpt_last;
                end
                got_n++;
                if (rpt_last) done = 1'b1;
            end
            prev_stall = !rpt_ready;
            prev_data  = rpt_data;
            prev_last  = rpt_last;
            tick();
        end
        rpt_ready = 1'b0;
        if (!done) chk("report_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_report(input string name, input bit narrow);
        chk($sformatf("%s_nwords", name), 32'(got_n), 32'd10);
        for (int k = 0; k < 10 && k < got_n; k++) begin
            chk($sformatf("%s_w%0d", name, k), narrow ? got_data4[k] : got_data[k], exp_w[k]);
            chk($sformatf("%s_last%0d", name, k), 32'(got_last[k]), 32'(k == 9));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_rpt_valid", 32'(rpt_valid), 32'd0);
        chk("rst_rpt_last", 32'(rpt_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);

        // Eight matching samples, always-ready sink
        do_start();
        chk("t1_busy_run", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) do_sample(4'(k), 4'(k));
        chk("t1_no_valid_in_run", 32'(rpt_valid), 32'd0);
        do_finish();
        chk("t1_busy_report", 32'(busy), 32'd1);
        collect(0);
        exp_w = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_report("t1", 1'b0);
        chk("t1_valid_done", 32'(rpt_valid), 32'd0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);

        // Bit 2 mismatches at timestamps 3 and 5, throttled sink
        do_start();
        chk("t2_pass_cleared", 32'(pass), 32'd0);
        for (int k = 0; k < 6; k++) do_sample(4'b0000, (k == 3 || k == 5) ? 4'b0100 : 4'b0000);
        do_finish();
        collect(1);
        exp_w = '{6, 2, 0, 0, 0, 0, 2, 3, 0, 0};
        check_report("t2", 1'b0);
        chk("t2_pass", 32'(pass), 32'd0);

        // Ignored events in DONE, start during RUN, sample with finish
        do_sample(4'b0000, 4'b1111);
        do_sample(4'b0000, 4'b1111);
        do_finish();
        chk("t3_done_finish_ignored", 32'(busy), 32'd0);
        chk("t3_done_no_valid", 32'(rpt_valid), 32'd0);
        do_start();
        do_sample(4'b0000, 4'b0000);
        do_sample(4'b0000, 4'b0001);
        do_sample(4'b1010, 4'b1010);
        start = 1'b1;
        do_sample(4'b0101, 4'b0101);
        start = 1'b0;
        chk("t3_start_in_run", 32'(busy), 32'd1);
        sample_valid = 1'b1;
        ref_vec      = 4'b0000;
        dut_vec      = 4'b1000;
        do_finish();
        sample_valid = 1'b0;
        dut_vec      = '0;
        collect(0);
        exp_w = '{5, 2, 1, 1, 0, 0, 0, 0, 1, 4};
        check_report("t3", 1'b0);

        // Reset while word 4 is presented
        do_start();
        do_sample(4'b0000, 4'b0010);
        do_sample(4'b0000, 4'b0010);
        do_finish();
        rpt_ready = 1'b1;
        repeat (4) tick();
        chk("t4_word4_valid", 32'(rpt_valid), 32'd1);
        chk("t4_word4_data", rpt_data, 32'd2);
        rpt_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        chk("t4_abort_valid", 32'(rpt_valid), 32'd0);
        chk("t4_abort_busy", 32'(busy), 32'd0);
        chk("t4_abort_last", 32'(rpt_last), 32'd0);
        do_start();
        do_finish();
        collect(0);
        exp_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_report("t4", 1'b0);
        chk("t4_pass", 32'(pass), 32'd1);

        // Saturation on the 4-bit counter instance
        do_reset();
        do_start();
        for (int k = 0; k < 20; k++) do_sample(4'b0000, 4'b1111);
        do_finish();
        collect(0);
        exp_w = '{15, 15, 15, 0, 15, 0, 15, 0, 15, 0};
        check_report("t5", 1'b1);
        chk("t5_wide_clocks", got_data[0], 32'd20);
        chk("t5_wide_errors", got_data[1], 32'd20);
        chk("t5_narrow_pass", 32'(pass4), 32'd0);
        chk("t5_narrow_valid", 32'(rpt_valid4), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
